// File: rtl/y_alu_pkg.sv
// Shared constants for the ALU issue stage: ALU op codes, opcode/funct
// encodings and the issue FSM state enum.
package y_alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/y_alu_decode.sv
// Combinational instruction decode: opcode/funct -> ALU op, immediate
// select, branch flags and unsupported-instruction error.
// Optional feature: Y_ALU_ISSUE_BNE_EN enables bne decode.
module y_alu_decode
  import y_alu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] op_o,
  output logic       use_imm_o,
  output logic       is_branch_o,
  output logic       br_inv_o,
  output logic       err_o
);

  // Map the instruction fields onto the external ALU controls.
  always_comb begin
    op_o        = ALU_AND;
    use_imm_o   = 1'b0;
    is_branch_o = 1'b0;
    br_inv_o    = 1'b0;
    err_o       = 1'b0;
    case (opcode_i)
      OPC_RTYPE: begin
        case (funct_i)
          FN_ADD:  op_o = ALU_ADD;
          FN_SUB:  op_o = ALU_SUB;
          FN_AND:  op_o = ALU_AND;
          FN_OR:   op_o = ALU_OR;
          FN_SLT:  op_o = ALU_SLT;
          default: err_o = 1'b1;
        endcase
      end
      OPC_ADDI: begin
        op_o      = ALU_ADD;
        use_imm_o = 1'b1;
      end
      OPC_BEQ: begin
        op_o        = ALU_SUB;
        is_branch_o = 1'b1;
      end
`ifdef Y_ALU_ISSUE_BNE_EN
      OPC_BNE: begin
        op_o        = ALU_SUB;
        is_branch_o = 1'b1;
        br_inv_o    = 1'b1;
      end
`endif
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/y_alu_issue.sv
// ALU issue stage: accepts one request in IDLE, drives the external
// combinational ALU for one ISSUE cycle, then holds the response in RESP
// until it is taken. Unsupported instructions skip ISSUE and respond
// with rsp_err. Optional feature: Y_ALU_ISSUE_BNE_EN (bne decode).
module y_alu_issue
  import y_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_opcode,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [15:0]      req_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_zero,
  output logic             rsp_taken,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             br_q, inv_q;
  logic [WIDTH-1:0] z_q;
  logic             zero_q, taken_q, err_q;

  logic [2:0] dec_op;
  logic       dec_imm, dec_br, dec_inv, dec_err;
  logic       accept;

  y_alu_decode u_dec (
    .opcode_i    (req_opcode),
    .funct_i     (req_funct),
    .op_o        (dec_op),
    .use_imm_o   (dec_imm),
    .is_branch_o (dec_br),
    .br_inv_o    (dec_inv),
    .err_o       (dec_err)
  );

  assign accept = req_valid && (state_q == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake/ALU outputs; ALU controls are zero outside ISSUE.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = dec_err ? RESP : ISSUE;
      end
      ISSUE: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_op  = op_q;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture at acceptance and result capture at the end of ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      br_q    <= 1'b0;
      inv_q   <= 1'b0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      a_q   <= req_a;
      b_q   <= dec_imm ? WIDTH'($signed(req_imm)) : req_b;
      op_q  <= dec_op;
      br_q  <= dec_br;
      inv_q <= dec_inv;
      // An unsupported request goes straight to RESP with a cleared result.
      z_q     <= '0;
      zero_q  <= 1'b0;
      taken_q <= 1'b0;
      err_q   <= dec_err;
    end else if (state_q == ISSUE) begin
      z_q     <= alu_z;
      zero_q  <= alu_zero;
      taken_q <= br_q & (alu_zero ^ inv_q);
      err_q   <= 1'b0;
    end
  end

  assign rsp_z     = z_q;
  assign rsp_zero  = zero_q;
  assign rsp_taken = taken_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_y_alu_issue.sv
// Bench for y_alu_issue: directed corner cases plus a randomized run,
// each checked against an instruction-level reference model. yAlu below
// plays the external combinational ALU.
module tb_y_alu_issue;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [5:0]   req_opcode = '0;
  logic [5:0]   req_funct = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [15:0]  req_imm = '0;
  logic [W-1:0] alu_a, alu_b, alu_z;
  logic [2:0]   alu_op;
  logic         alu_zero;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_z;
  logic         rsp_zero, rsp_taken, rsp_err;

  int n_chk = 0;
  int n_fail = 0;

  y_alu_issue #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_zero(rsp_zero), .rsp_taken(rsp_taken), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // External ALU.
  always_comb begin : yAlu
    case (alu_op)
      3'b010:  alu_z = alu_a + alu_b;
      3'b110:  alu_z = alu_a - alu_b;
      3'b000:  alu_z = alu_a & alu_b;
      3'b001:  alu_z = alu_a | alu_b;
      3'b111:  alu_z = ($signed(alu_a) < $signed(alu_b)) ? W'(1) : W'(0);
      default: alu_z = '0;
    endcase
    alu_zero = (alu_z == '0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result of one instruction.
  typedef struct {
    bit           err;
    bit [2:0]     op;
    bit [W-1:0]   b;
    bit [W-1:0]   z;
    bit           zero;
    bit           taken;
  } exp_t;

  function automatic exp_t model(input bit [5:0] opc, input bit [5:0] fn,
                                 input bit [W-1:0] a, input bit [W-1:0] b,
                                 input bit [15:0] imm);
    exp_t e;
    bit [W-1:0] sx;
    sx = {{(W-16){imm[15]}}, imm};
    e.err = 0; e.op = 0; e.b = b; e.z = 0; e.taken = 0;
    if (opc == 6'h00) begin
      if      (fn == 6'h20) begin e.op = 3'b010; e.z = a + b; end
      else if (fn == 6'h22) begin e.op = 3'b110; e.z = a - b; end
      else if (fn == 6'h24) begin e.op = 3'b000; e.z = a & b; end
      else if (fn == 6'h25) begin e.op = 3'b001; e.z = a | b; end
      else if (fn == 6'h2A) begin e.op = 3'b111; e.z = ($signed(a) < $signed(b)) ? 1 : 0; end
      else e.err = 1;
    end else if (opc == 6'h08) begin
      e.op = 3'b010; e.b = sx; e.z = a + sx;
    end else if (opc == 6'h04) begin
      e.op = 3'b110; e.z = a - b; e.taken = (a == b);
`ifdef Y_ALU_ISSUE_BNE_EN
    end else if (opc == 6'h05) begin
      e.op = 3'b110; e.z = a - b; e.taken = (a != b);
`endif
    end else begin
      e.err = 1;
    end
    e.zero = !e.err && (e.z == 0);
    return e;
  endfunction

  // Issue one request, check the ISSUE cycle, latency and response, optionally
  // stall the response for `hold` cycles while offering another request.
  task automatic run(input string nm, input bit [5:0] opc, input bit [5:0] fn,
                     input bit [W-1:0] a, input bit [W-1:0] b, input bit [15:0] imm,
                     input int hold);
    exp_t e;
    e = model(opc, fn, a, b, imm);
    @(negedge clk);
    chk({nm, ".req_ready"}, req_ready, 1);
    req_valid = 1; req_opcode = opc; req_funct = fn; req_a = a; req_b = b; req_imm = imm;
    @(posedge clk); #1;
    req_valid = 0;
    if (!e.err) begin
      chk({nm, ".issue_vld"}, rsp_valid, 0);
      chk({nm, ".alu_op"}, alu_op, e.op);
      chk({nm, ".alu_a"}, alu_a, a);
      chk({nm, ".alu_b"}, alu_b, e.b);
      @(posedge clk); #1;
    end else begin
      chk({nm, ".err_alu_op"}, alu_op, 0);
    end
    chk({nm, ".rsp_valid"}, rsp_valid, 1);
    chk({nm, ".rsp_z"}, rsp_z, e.z);
    chk({nm, ".rsp_zero"}, rsp_zero, e.zero);
    chk({nm, ".rsp_taken"}, rsp_taken, e.taken);
    chk({nm, ".rsp_err"}, rsp_err, e.err);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_opcode = 6'h00; req_funct = 6'h20; req_a = 1; req_b = 1;
      @(posedge clk); #1;
      chk({nm, ".hold_valid"}, rsp_valid, 1);
      chk({nm, ".hold_ready"}, req_ready, 0);
      chk({nm, ".hold_z"}, rsp_z, e.z);
      chk({nm, ".hold_taken"}, rsp_taken, e.taken);
      chk({nm, ".hold_err"}, rsp_err, e.err);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk({nm, ".done_valid"}, rsp_valid, 0);
    chk({nm, ".done_ready"}, req_ready, 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".alu_a"}, alu_a, 0);
    chk({nm, ".alu_b"}, alu_b, 0);
    chk({nm, ".alu_op"}, alu_op, 0);
    chk({nm, ".rsp_valid"}, rsp_valid, 0);
    chk({nm, ".rsp_z"}, rsp_z, 0);
    chk({nm, ".rsp_zero"}, rsp_zero, 0);
    chk({nm, ".rsp_taken"}, rsp_taken, 0);
    chk({nm, ".rsp_err"}, rsp_err, 0);
  endtask

  initial begin
    bit [5:0]  opc, fn;
    bit [W-1:0] a, b;
    bit [15:0] imm;
    int sel;

    #12;
    chk_all_zero("reset");
    chk("reset.req_ready", req_ready, 1);
    @(negedge clk); rst_n = 1;

    run("add",   6'h00, 6'h20, 5, 7, 0, 0);
    run("sub",   6'h00, 6'h22, 32'h1234, 32'h1234, 0, 0);
    run("addi",  6'h08, 6'h00, 1, 0, 16'hFFFF, 0);
    run("beq_t", 6'h04, 6'h00, 9, 9, 0, 0);
    run("beq_n", 6'h04, 6'h00, 9, 8, 0, 0);
    run("bne",   6'h05, 6'h00, 9, 8, 0, 0);
    run("f27",   6'h00, 6'h27, 3, 4, 0, 0);
    run("slt",   6'h00, 6'h2A, 32'hFFFF_FFFF, 1, 0, 0);
    run("wrap",  6'h00, 6'h20, 32'hFFFF_FFFF, 2, 0, 0);
    run("stall", 6'h00, 6'h25, 32'hF0, 32'h0F, 0, 5);

    // Reset pulsed while a request sits in ISSUE.
    @(negedge clk);
    req_valid = 1; req_opcode = 6'h00; req_funct = 6'h20; req_a = 3; req_b = 4;
    @(posedge clk); #1;
    req_valid = 0;
    chk("rst_mid.in_issue", alu_op, 3'b010);
    #2 rst_n = 0;
    #1 chk_all_zero("rst_mid");
    chk("rst_mid.req_ready", req_ready, 1);
    @(negedge clk); rst_n = 1;
    chk("rst_mid.rel_ready", req_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_mid.no_rsp", rsp_valid, 0);
    end

    // Randomized mix of supported and unsupported instructions.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      imm = 16'($urandom); fn = 6'($urandom);
      case (sel)
        0: begin opc = 6'h00; fn = 6'h20; end
        1: begin opc = 6'h00; fn = 6'h22; end
        2: begin opc = 6'h00; fn = 6'h24; end
        3: begin opc = 6'h00; fn = 6'h25; end
        4: begin opc = 6'h00; fn = 6'h2A; end
        5: opc = 6'h08;
        6: opc = 6'h04;
        7: opc = 6'h05;
        8: opc = 6'h00;
        default: opc = 6'($urandom);
      endcase
      run("rand", opc, fn, a, b, imm, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/y_alu_issue.md
Y_ALU_ISSUE -- requirements
Module: y_alu_issue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, meaning the request fields are valid.
REQ-005 SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-006 SHALL have port req_opcode, input, 6, the instruction opcode.
REQ-007 SHALL have port req_funct, input, 6, the R-type function field.
REQ-008 SHALL have ports req_a and req_b, input, WIDTH, the rs and rt operand values.
REQ-009 SHALL have port req_imm, input, 16, the immediate field.
REQ-010 SHALL have ports alu_a and alu_b, output, WIDTH, driving the external ALU operands.
REQ-011 SHALL have port alu_op, output, 3, driving the external ALU operation.
REQ-012 SHALL have ports alu_z, input, WIDTH, and alu_zero, input, 1, the ALU result and zero flag; the ALU path is combinational.
REQ-013 SHALL have ports rsp_valid, output, 1, and rsp_ready, input, 1, forming the response handshake.
REQ-014 SHALL have ports rsp_z, output, WIDTH; rsp_zero, output, 1; rsp_taken, output, 1; and rsp_err, output, 1.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 SHALL decode at acceptance:
- R-type (opcode 0x00): funct 0x20 add->010, 0x22 sub->110, 0x24 and->000, 0x25 or->001, 0x2A slt->111.
- addi (0x08): op 010, alu_b = sign-extended req_imm.
- beq (0x04): op 110.
REQ-018 SHALL register the operands and op on acceptance; an accepted request moves the FSM IDLE->ISSUE, or IDLE->RESP if the decode is unsupported.
REQ-019 SHALL drive alu_a, alu_b and alu_op from the registered values only in ISSUE, and drive all three to 0 in every other state.
REQ-020 SHALL capture alu_z->rsp_z and alu_zero->rsp_zero at the end of ISSUE, then go to RESP; response latency is exactly 2 edges from acceptance.
REQ-021 SHALL set rsp_taken=alu_zero for beq, and rsp_taken=0 for all non-branch operations.
REQ-022 SHALL, for an unsupported opcode/funct, set rsp_err=1, rsp_z=0, rsp_zero=0 and rsp_taken=0, and perform no ISSUE cycle.
REQ-023 SHALL hold rsp_valid=1 in RESP, with all rsp_* outputs stable, until rsp_ready=1; then go RESP->IDLE on that edge.
REQ-024 SHALL ignore req_valid outside IDLE; back-to-back throughput is at most 1 request per 3 cycles.
REQ-025 SHALL treat the operands as unsigned for add/sub width purposes, so the result wraps modulo 2^WIDTH and no carry is reported.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, all registered operands to 0, and rsp_valid, rsp_z, rsp_zero, rsp_taken, rsp_err, alu_a, alu_b, alu_op to 0, independent of clk.
REQ-027 SHALL, on reset asserted in ISSUE or RESP, abandon the in-flight request with no response; after release req_ready=1.

Configuration
REQ-028 SHALL, with Y_ALU_ISSUE_BNE_EN defined, decode bne (0x05) as op 110 with rsp_taken=!alu_zero.
REQ-029 SHALL, without Y_ALU_ISSUE_BNE_EN, treat opcode 0x05 as unsupported (REQ-022).

Structure
REQ-030 SHALL place the ALU op codes, the opcode/funct constants and the FSM state enum in the shared package y_alu_pkg.
REQ-031 SHALL put the combinational decode (opcode/funct/imm -> op, b-select, is_branch, err) in the sub-module y_alu_decode; the FSM and registers stay in y_alu_issue.

Verification (bench instantiates y_alu_issue with yAlu as the external ALU)
REQ-032 SHALL cover: add, a=5, b=7 -> alu_op=010 in ISSUE; rsp_z=12, rsp_zero=0, rsp_valid 2 edges after acceptance.
REQ-033 SHALL cover: sub, a=b=0x1234 -> rsp_z=0, rsp_zero=1; addi, a=1, imm=0xFFFF -> rsp_z=0.
REQ-034 SHALL cover: beq, a=b=9 -> rsp_taken=1; beq, a=9, b=8 -> rsp_taken=0; bne, a=9, b=8 -> rsp_taken=1 with the macro defined, and rsp_err=1 without it.
REQ-035 SHALL cover: funct 0x27 -> rsp_err=1, rsp_z=0, rsp_valid 1 edge after acceptance, alu_op stays 0.
REQ-036 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0, and a new req_valid is not accepted.
REQ-037 SHALL cover: rst_n pulsed low in ISSUE -> all outputs 0 immediately, no response emitted, req_ready=1 after release.
